// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
// Drives the J/K/enable pins of an external JK latch to move it to a
// requested state, then checks the latch output and reports the result.
//
// Sequence per request: IDLE -> SETUP (1 cycle, J/K applied, enable low)
//   -> PULSE (PULSE_CYCLES, enable high) -> HOLD (SETTLE_CYCLES, enable low)
//   -> CHECK (1 cycle, done pulse, mismatch if q != target) -> IDLE.
//
// Build option: define JK_TOGGLE_EXCITATION_EN to drive J=1 K=1 (toggle)
// for changing transitions instead of the default set/reset excitation.
//
// Ports:
//   cp           clock, rising edge
//   notreset     asynchronous active-low reset
//   target       requested next latch state
//   targetValid  target offered
//   targetReady  block accepts a target (registered, IDLE only)
//   q            latch Q output
//   jack, kilby  J and K drive to the latch
//   enable       latch enable pulse
//   done         one-cycle pulse when the transition is complete
//   mismatch     one-cycle pulse with done when q differs from target
//   errCount     saturating mismatch count
`timescale 1ns/1ps
module jk_excitation_driver #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PULSE_CYCLES  = 1
) (
  input  logic       cp,
  input  logic       notreset,
  input  logic       target,
  input  logic       targetValid,
  output logic       targetReady,
  input  logic       q,
  output logic       jack,
  output logic       kilby,
  output logic       enable,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] errCount
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [2:0] state;
  logic [2:0] state_nx;
  logic [3:0] cnt;
  logic       tgt;
  logic       accept;
  logic       drive_nx;
  logic       mism_nx;
  logic [1:0] jk_nx;

  // Returns {J, K} for a move from current latch state qp to requested t.
  function automatic logic [1:0] excite(input logic qp, input logic t);
`ifdef JK_TOGGLE_EXCITATION_EN
    excite = (qp != t) ? 2'b11 : 2'b00;
`else
    excite = {t & ~qp, ~t & qp};
`endif
  endfunction

  assign accept = (state == IDLE) && targetReady && targetValid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = PULSE;
      PULSE:   if (cnt == PULSE_LAST) state_nx = HOLD;
      HOLD:    if (cnt == SETTLE_LAST) state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // J/K are computed from the live target and q at the handshake edge and
  // then simply recirculate from the output registers until CHECK.
  always_comb begin
    jk_nx    = accept ? excite(q, target) : {jack, kilby};
    drive_nx = (state_nx == SETUP) || (state_nx == PULSE) || (state_nx == HOLD);
    mism_nx  = (state_nx == CHECK) && (q != tgt);
  end

  // Every output is registered from the next-state decode so it lines up
  // with the state it belongs to.
  always_ff @(posedge cp or negedge notreset) begin
    if (!notreset) begin
      state       <= IDLE;
      cnt         <= '0;
      targetReady <= 1'b0;
      jack        <= 1'b0;
      kilby       <= 1'b0;
      enable      <= 1'b0;
      done        <= 1'b0;
      mismatch    <= 1'b0;
      errCount    <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
      targetReady <= (state_nx == IDLE);
      jack        <= drive_nx & jk_nx[1];
      kilby       <= drive_nx & jk_nx[0];
      enable      <= (state_nx == PULSE);
      done        <= (state_nx == CHECK);
      mismatch    <= mism_nx;
      if (mism_nx && (errCount != 8'hFF)) errCount <= errCount + 8'd1;
    end
  end

  // Requested state, captured at the handshake for the final comparison.
  always_ff @(posedge cp) begin
    if (accept) tgt <= target;
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
`timescale 1ns/1ps
module tb_jk_excitation_driver;

  logic       cp = 1'b0;
  logic       notreset = 1'b0;
  logic       target = 1'b0;
  logic       targetValid = 1'b0;
  logic       targetReady;
  logic       q;
  logic       jack;
  logic       kilby;
  logic       enable;
  logic       done;
  logic       mismatch;
  logic [7:0] errCount;

  logic q_drv = 1'b0;
  logic q_model = 1'b0;
  logic model_en = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef JK_TOGGLE_EXCITATION_EN
  localparam logic TOG = 1'b1;
`else
  localparam logic TOG = 1'b0;
`endif

  jk_excitation_driver dut (
    .cp(cp), .notreset(notreset), .target(target), .targetValid(targetValid),
    .targetReady(targetReady), .q(q), .jack(jack), .kilby(kilby),
    .enable(enable), .done(done), .mismatch(mismatch), .errCount(errCount)
  );

  always #5 cp = ~cp;

  // External latch model: follows q_drv while disabled, obeys J/K on enable otherwise.
  always @(posedge cp) begin
    if (!model_en) q_model <= q_drv;
    else if (enable) begin
      if (jack && kilby) q_model <= ~q_model;
      else if (jack)     q_model <= 1'b1;
      else if (kilby)    q_model <= 1'b0;
    end
  end
  assign q = model_en ? q_model : q_drv;

  typedef struct {
    logic       q0;
    logic       tg;
    logic       model;
    logic       ej;
    logic       ek;
    logic       emm;
    logic [7:0] eerr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (targetReady !== 1'b1 && n < 20) begin
      @(negedge cp);
      n++;
    end
    chk("ready_wait", int'(targetReady), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    model_en = 1'b0;
    q_drv = v.q0;
    @(negedge cp);
    @(negedge cp);
    model_en = v.model;
    wait_ready();
    target = v.tg;
    targetValid = 1'b1;
    @(negedge cp);
    targetValid = 1'b0;
    chk($sformatf("v%0d_setup_j", idx), int'(jack), int'(v.ej));
    chk($sformatf("v%0d_setup_k", idx), int'(kilby), int'(v.ek));
    chk($sformatf("v%0d_setup_en", idx), int'(enable), 0);
    chk($sformatf("v%0d_setup_rdy", idx), int'(targetReady), 0);
    @(negedge cp);
    chk($sformatf("v%0d_pulse_en", idx), int'(enable), 1);
    chk($sformatf("v%0d_pulse_jk", idx), int'({jack, kilby}), int'({v.ej, v.ek}));
    @(negedge cp);
    chk($sformatf("v%0d_hold_en", idx), int'(enable), 0);
    chk($sformatf("v%0d_hold_jk", idx), int'({jack, kilby}), int'({v.ej, v.ek}));
    chk($sformatf("v%0d_hold_done", idx), int'(done), 0);
    @(negedge cp);
    chk($sformatf("v%0d_check_done", idx), int'(done), 1);
    chk($sformatf("v%0d_check_mm", idx), int'(mismatch), int'(v.emm));
    chk($sformatf("v%0d_check_jk", idx), int'({jack, kilby}), 0);
    chk($sformatf("v%0d_check_err", idx), int'(errCount), int'(v.eerr));
    @(negedge cp);
    chk($sformatf("v%0d_idle_done", idx), int'(done), 0);
    chk($sformatf("v%0d_idle_mm", idx), int'(mismatch), 0);
    chk($sformatf("v%0d_idle_rdy", idx), int'(targetReady), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int last;
    int gaps_bad;
    int nready;
    int ndone;
    int nmm;

    //            q0    tg    model ej    ek    mm    err
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, TOG,  1'b0, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, TOG,  1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, TOG,  1'b1, 8'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, TOG,  1'b1, 1'b1, 8'd2};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};

    // Reset state
    #12;
    chk("rst_ready", int'(targetReady), 0);
    chk("rst_jk", int'({jack, kilby}), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_err", int'(errCount), 0);
    @(negedge cp);
    notreset = 1'b1;
    #1;
    chk("rel_ready_before_edge", int'(targetReady), 0);
    @(negedge cp);
    chk("rel_ready_after_edge", int'(targetReady), 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while the enable pulse is active
    model_en = 1'b0;
    q_drv = 1'b0;
    wait_ready();
    target = 1'b1;
    targetValid = 1'b1;
    @(negedge cp);
    targetValid = 1'b0;
    @(negedge cp);
    chk("abort_pulse_en", int'(enable), 1);
    #2;
    notreset = 1'b0;
    #1;
    chk("abort_en_now", int'(enable), 0);
    chk("abort_jk_now", int'({jack, kilby}), 0);
    chk("abort_ready_now", int'(targetReady), 0);
    chk("abort_err_now", int'(errCount), 0);
    @(negedge cp);
    notreset = 1'b1;
    #1;
    chk("abort_ready_pre", int'(targetReady), 0);
    @(negedge cp);
    chk("abort_ready_post", int'(targetReady), 1);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || mismatch) ndone++;
      @(negedge cp);
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_err_after", int'(errCount), 0);

    // Back-to-back requests with the latch ignoring enable
    model_en = 1'b0;
    q_drv = 1'b0;
    target = 1'b1;
    wait_ready();
    targetValid = 1'b1;
    last = -1;
    gaps_bad = 0;
    nready = 0;
    ndone = 0;
    nmm = 0;
    for (int c = 0; c < 1502; c++) begin
      if (targetReady) begin
        if (last >= 0 && (c - last) != 5) gaps_bad++;
        last = c;
        nready++;
      end
      if (done) begin
        ndone++;
        if (ndone == 10) chk("stream_err_at_10", int'(errCount), 10);
      end
      if (mismatch) nmm++;
      @(negedge cp);
    end
    targetValid = 1'b0;
    chk("stream_gaps", gaps_bad, 0);
    chk("stream_accepts", nready, 301);
    chk("stream_done", ndone, 300);
    chk("stream_mismatch", nmm, 300);
    chk("stream_err_sat", int'(errCount), 255);
    wait_ready();
    @(negedge cp);
    chk("stream_err_sat_final", int'(errCount), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
